// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// ==========================================================================
// adder_seq_ctrl : WIDTH-bit add sequenced 4 bits per cycle through a shared
//                  external 4-bit adder.                       Revision: 1.0
// ==========================================================================
module adder_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_ci,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_co,
  output logic [7:0]       op_count,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_ci,
  input  logic [3:0]       add_sum,
  input  logic             add_co
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             carry_q, carry_d, rsp_co_q, rsp_co_d;
  logic [7:0]       op_count_q, op_count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      rsp_sum_q  <= '0;
      rsp_co_q   <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      rsp_sum_q  <= rsp_sum_d;
      rsp_co_q   <= rsp_co_d;
      op_count_q <= op_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    rsp_sum_d  = rsp_sum_q;
    rsp_co_d   = rsp_co_q;
    op_count_d = op_count_q;
    add_a      = 4'h0;
    add_b      = 4'h0;
    add_ci     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          carry_d = req_ci;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_ci  = carry_q;
        carry_d = add_co;
        for (int i = 0; i < NSLICE; i++) begin
          if (idx_q == i[IDXW-1:0]) begin
            add_a             = a_q[4*i +: 4];
            add_b             = b_q[4*i +: 4];
            sum_d[4*i +: 4]   = add_sum;
          end
        end
        // Response registers are separate so the result holds through the next op.
        if (idx_q == LAST_IDX) begin
          rsp_sum_d = sum_d;
          rsp_co_d  = add_co;
          state_d   = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + 8'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = rsp_sum_q;
  assign rsp_co    = rsp_co_q;
  assign op_count  = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
`default_nettype none
// Testbench for adder_seq_ctrl (WIDTH=16) with a behavioural 4-bit adder and
// a scoreboard of expected results.
module tb_adder_seq_ctrl;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [WIDTH-1:0] req_a = '0;
  logic [WIDTH-1:0] req_b = '0;
  logic             req_ci = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_co;
  logic [7:0]       op_count;
  logic [3:0]       add_a, add_b, add_sum;
  logic             add_ci, add_co;

  adder_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_co(rsp_co), .op_count(op_count),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_sum(add_sum), .add_co(add_co)
  );

  assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_ci};

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             co;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [3:0] seq_a [NSLICE];
  logic       seq_ci[NSLICE];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ci);
    logic [WIDTH:0] f;
    exp_t e;
    f = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    e.sum = f[WIDTH-1:0];
    e.co  = f[WIDTH];
    return e;
  endfunction

  task automatic pop_check(input string tag);
    exp_t got;
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check({tag, " rsp_sum"}, 32'(rsp_sum), 32'(got.sum));
      check({tag, " rsp_co"}, 32'(rsp_co), 32'(got.co));
    end
  endtask

  // One full transaction; bp = number of DONE cycles with rsp_ready low.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                       input int bp, input string tag);
    exp_t e;
    int   n;
    e = model(a, b, ci);
    req_a = a; req_b = b; req_ci = ci; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    check({tag, " req_ready_idle"}, 32'(req_ready), 32'd1);
    sb.push_back(e);
    tick();
    req_valid = 1'b0;
    req_a = WIDTH'($urandom); req_b = WIDTH'($urandom); req_ci = 1'($urandom);
    check({tag, " accepted"}, 32'(req_ready), 32'd0);
    for (int k = 0; k < NSLICE; k++) begin
      seq_a[k]  = add_a;
      seq_ci[k] = add_ci;
      if (k == NSLICE - 1) check({tag, " early_valid"}, 32'(rsp_valid), 32'd0);
      tick();
    end
    check({tag, " latency_valid"}, 32'(rsp_valid), 32'd1);
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    check({tag, " op_count_pre"}, 32'(op_count), 32'(exp_cnt));
    if (bp > 0) begin
      req_valid = 1'b1;
      for (int k = 0; k < bp; k++) begin
        check({tag, " bp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " bp_sum"}, 32'(rsp_sum), 32'(e.sum));
        check({tag, " bp_co"}, 32'(rsp_co), 32'(e.co));
        check({tag, " bp_ready"}, 32'(req_ready), 32'd0);
        check({tag, " bp_count"}, 32'(op_count), 32'(exp_cnt));
        tick();
      end
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    pop_check(tag);
    tick();
    rsp_ready = 1'b0;
    exp_cnt++;
    check({tag, " op_count_post"}, 32'(op_count), 32'(exp_cnt));
    check({tag, " valid_dropped"}, 32'(rsp_valid), 32'd0);
    check({tag, " sum_hold"}, 32'(rsp_sum), 32'(e.sum));
  endtask

  initial begin
    int   done, cyc, last_hs;
    logic acc, hs;
    exp_t e;

    // Reset state
    #3;
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst op_count", 32'(op_count), 32'd0);
    check("rst add_a", 32'(add_a), 32'd0);
    check("rst rsp_sum", 32'(rsp_sum), 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // rsp_ready in IDLE does nothing
    rsp_ready = 1'b1;
    tick(); tick();
    check("idle rsp_ready count", 32'(op_count), 32'd0);
    check("idle rsp_ready valid", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;

    do_op(16'h00A3, 16'h0F02, 1'b0, 0, "basic");
    check("basic add_a0", 32'(seq_a[0]), 32'h3);
    check("basic add_a1", 32'(seq_a[1]), 32'hA);
    check("basic add_a2", 32'(seq_a[2]), 32'h0);
    check("basic add_a3", 32'(seq_a[3]), 32'h0);

    do_op(16'hFFFF, 16'h0001, 1'b0, 0, "ripple");
    check("ripple add_ci0", 32'(seq_ci[0]), 32'd0);
    check("ripple add_ci1", 32'(seq_ci[1]), 32'd1);
    check("ripple add_ci2", 32'(seq_ci[2]), 32'd1);
    check("ripple add_ci3", 32'(seq_ci[3]), 32'd1);

    do_op(16'hFFFF, 16'h0000, 1'b1, 0, "cin_ripple");
    do_op(16'h1234, 16'h4321, 1'b1, 0, "cin_plain");
    do_op(16'hBEEF, 16'h1234, 1'b0, 3, "backpressure");

    // Reset in the middle of RUN (idx=2)
    req_a = 16'h5A5A; req_b = 16'h1111; req_ci = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    check("midrun add_a idx2", 32'(add_a), 32'hA);
    #2 rst_n = 1'b0;
    #1;
    check("async rsp_valid", 32'(rsp_valid), 32'd0);
    check("async rsp_sum", 32'(rsp_sum), 32'd0);
    check("async rsp_co", 32'(rsp_co), 32'd0);
    check("async op_count", 32'(op_count), 32'd0);
    check("async add_a", 32'(add_a), 32'd0);
    check("async add_b", 32'(add_b), 32'd0);
    check("async add_ci", 32'(add_ci), 32'd0);
    check("async req_ready", 32'(req_ready), 32'd1);
    #2 rst_n = 1'b1;
    exp_cnt = 8'd0;
    do_op(16'h0001, 16'h0001, 1'b0, 0, "post_rst");

    // Throughput and op_count wrap from a clean reset
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    exp_cnt = 8'd0;
    tick();
    req_a = WIDTH'($urandom); req_b = WIDTH'($urandom); req_ci = 1'($urandom);
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    done = 0; cyc = 0; last_hs = -1;
    while (done < 257 && cyc < 257 * 6 + 50) begin
      acc = req_valid && req_ready;
      hs  = rsp_valid && rsp_ready;
      if (acc) begin
        e = model(req_a, req_b, req_ci);
        sb.push_back(e);
      end
      if (hs) begin
        pop_check("thru");
        if (last_hs >= 0) check("thru period", 32'(cyc - last_hs), 32'd6);
        last_hs = cyc;
      end
      tick();
      cyc++;
      if (acc) begin
        req_a = WIDTH'($urandom); req_b = WIDTH'($urandom); req_ci = 1'($urandom);
      end
      if (hs) begin
        done++;
        exp_cnt++;
        check("thru op_count", 32'(op_count), 32'(exp_cnt));
        if (done == 255) check("wrap 255", 32'(op_count), 32'd255);
        if (done == 256) check("wrap 0", 32'(op_count), 32'd0);
        if (done == 257) check("wrap 1", 32'(op_count), 32'd1);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("thru completed", 32'(done), 32'd257);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
